// File: rtl/mem_arbiter.sv
// Shares one SRAM port between the CPU and a loader; request-to-ack latency is WAIT_CYCLES+1 cycles.
// Level-held requests wait while busy; define MEM_ARB_RR_EN for round-robin instead of fixed CPU priority.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic        ldr_ack,
  output logic [15:0] ldr_rdata,
  output logic [15:0] ADDR,
  output logic        OE,
  output logic        WE,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       op_we;
  logic       win_ldr;
  logic       pick_ldr;
  logic       any_req;
  logic       last_cyc;

  assign any_req  = cpu_req | ldr_req;
  assign last_cyc = (cnt == 4'd0);

`ifdef MEM_ARB_RR_EN
  logic last_ldr;

  // On a tie the port that did not win last time gets the grant.
  assign pick_ldr = ldr_req & (~cpu_req | ~last_ldr);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      last_ldr <= 1'b1;
    else if (state == IDLE && any_req)
      last_ldr <= pick_ldr;
  end
`else
  assign pick_ldr = ~cpu_req;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Strobes and acks decode straight from the state so reset releases them immediately.
  always_comb begin
    state_nxt = state;
    OE        = 1'b1;
    WE        = 1'b1;
    cpu_ack   = 1'b0;
    ldr_ack   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        OE = op_we;
        WE = ~op_we;
        if (last_cyc) state_nxt = DONE;
      end
      DONE: begin
        cpu_ack   = ~win_ldr;
        ldr_ack   = win_ldr;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ADDR         <= 16'h0000;
      Data_to_SRAM <= 16'h0000;
      op_we        <= 1'b0;
      win_ldr      <= 1'b0;
      cnt          <= 4'd0;
      cpu_rdata    <= 16'h0000;
      ldr_rdata    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            win_ldr      <= pick_ldr;
            ADDR         <= pick_ldr ? ldr_addr  : cpu_addr;
            Data_to_SRAM <= pick_ldr ? ldr_wdata : cpu_wdata;
            op_we        <= pick_ldr ? ldr_we    : cpu_we;
            cnt          <= 4'(WAIT_CYCLES - 1);
          end
        end
        ACCESS: begin
          if (!last_cyc) cnt <= cnt - 4'd1;
          if (last_cyc && !op_we) begin
            if (win_ldr) ldr_rdata <= Data_from_SRAM;
            else         cpu_rdata <= Data_from_SRAM;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a WAIT_CYCLES=2 instance for most scenarios, a WAIT_CYCLES=1 instance for held requests.
module tb_mem_arbiter;
  logic        Clk, Reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, Data_from_SRAM;
  logic        cpu_ack, ldr_ack, OE, WE, busy;
  logic [15:0] cpu_rdata, ldr_rdata, ADDR, Data_to_SRAM;

  logic        c1_req, c1_ack, l1_ack, oe1, we1, busy1;
  logic [15:0] d1, c1_rdata, l1_rdata, addr1, dts1;
  logic        zero1;
  logic [15:0] zero16;

  int n_checks;
  int n_errors;

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .ADDR(ADDR), .OE(OE), .WE(WE), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM), .busy(busy)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(c1_req), .cpu_we(zero1), .cpu_addr(zero16), .cpu_wdata(zero16),
    .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
    .ldr_req(zero1), .ldr_we(zero1), .ldr_addr(zero16), .ldr_wdata(zero16),
    .ldr_ack(l1_ack), .ldr_rdata(l1_rdata),
    .ADDR(addr1), .OE(oe1), .WE(we1), .Data_to_SRAM(dts1),
    .Data_from_SRAM(d1), .busy(busy1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  initial begin
    int  ng;
    int  lat;
    int  acks;
    logic gr [3];
    logic exp_second;
    int  ack_cyc [2];
    logic [15:0] ack_dat [2];

    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    Data_from_SRAM = 0;
    c1_req = 0; d1 = 0; zero1 = 0; zero16 = 0;
    repeat (3) cyc();

    // Reset values
    check("rst_addr", ADDR, 16'h0000);
    check("rst_dts", Data_to_SRAM, 16'h0000);
    check("rst_oe", OE, 1);
    check("rst_we", WE, 1);
    check("rst_acks", {cpu_ack, ldr_ack}, 0);
    check("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    check("rst_busy", busy, 0);
    Reset = 1'b0;
    cyc();

    // CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; Data_from_SRAM = 16'hBEEF;
    cyc();
    check("rd_c1_oe", OE, 0);
    check("rd_c1_we", WE, 1);
    check("rd_c1_addr", ADDR, 16'h0010);
    check("rd_c1_busy", busy, 1);
    cyc();
    check("rd_c2_oe", OE, 0);
    check("rd_c2_ack", cpu_ack, 0);
    cyc();
    check("rd_c3_ack", cpu_ack, 1);
    check("rd_c3_oe", OE, 1);
    check("rd_rdata", cpu_rdata, 16'hBEEF);
    check("rd_ldr_rdata", ldr_rdata, 16'h0000);
    cpu_req = 0;
    cyc();
    check("rd_c4_busy", busy, 0);
    check("rd_c4_ack", cpu_ack, 0);

    // Loader write
    ldr_req = 1; ldr_we = 1; ldr_addr = 16'h3000; ldr_wdata = 16'h1234;
    cyc();
    check("wr_c1_addr", ADDR, 16'h3000);
    check("wr_c1_dts", Data_to_SRAM, 16'h1234);
    check("wr_c1_strobes", {OE, WE}, 2'b10);
    cyc();
    check("wr_c2_strobes", {OE, WE}, 2'b10);
    check("wr_c2_ack", ldr_ack, 0);
    cyc();
    check("wr_c3_ack", ldr_ack, 1);
    check("wr_c3_strobes", {OE, WE}, 2'b11);
    check("wr_rdata", {cpu_rdata, ldr_rdata}, {16'hBEEF, 16'h0000});
    ldr_req = 0;
    cyc();

    // Both requesting continuously for three transactions
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
    ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0200;
    Data_from_SRAM = 16'hC0DE;
    ng = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (cpu_ack || ldr_ack) begin
        if (ng < 3) gr[ng] = ldr_ack;
        ng++;
      end
    end
    cpu_req = 0; ldr_req = 0;
`ifdef MEM_ARB_RR_EN
    exp_second = 1'b1;
`else
    exp_second = 1'b0;
`endif
    check("both_ngrants", ng, 3);
    check("both_g0", gr[0], 0);
    check("both_g1", gr[1], exp_second);
    check("both_g2", gr[2], 0);
    cyc();

    // Reset during the 2nd ACCESS cycle of a CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020; Data_from_SRAM = 16'h5555;
    cyc();
    check("mrst_c1_oe", OE, 0);
    cyc();
    #1 Reset = 1'b1;
    #1;
    check("mrst_oe", OE, 1);
    check("mrst_busy", busy, 0);
    check("mrst_ack", cpu_ack, 0);
    check("mrst_rdata", cpu_rdata, 16'h0000);
    cpu_req = 0;
    cyc();
    Reset = 1'b0;
    acks = 0;
    repeat (3) begin
      cyc();
      if (cpu_ack) acks++;
    end
    check("mrst_no_ack", acks, 0);
    cpu_req = 1; cpu_addr = 16'h0030; Data_from_SRAM = 16'h0A0A;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (cpu_ack) begin
        lat = k;
        break;
      end
    end
    check("mrst_recover_lat", lat, 3);
    check("mrst_recover_rdata", cpu_rdata, 16'h0A0A);
    cpu_req = 0;
    cyc();

    // WAIT_CYCLES=1 with the request held through ack
    d1 = 16'h0001; c1_req = 1;
    ng = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (c1_ack) begin
        if (ng < 2) begin
          ack_cyc[ng] = i;
          ack_dat[ng] = c1_rdata;
        end
        ng++;
        d1 = 16'h0002;
      end
    end
    c1_req = 0;
    check("held_nacks", ng, 2);
    check("held_ack0_cyc", ack_cyc[0], 2);
    check("held_ack1_cyc", ack_cyc[1], 5);
    check("held_dat0", ack_dat[0], 16'h0001);
    check("held_dat1", ack_dat[1], 16'h0002);
    cyc();

    // Loader request arriving mid CPU access
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; Data_from_SRAM = 16'h1111;
    cyc();
    ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0050;
    cyc();
    check("late_c2_ldr_ack", ldr_ack, 0);
    check("late_c2_addr", ADDR, 16'h0040);
    cyc();
    check("late_cpu_ack", cpu_ack, 1);
    check("late_cpu_rdata", cpu_rdata, 16'h1111);
    cpu_req = 0; Data_from_SRAM = 16'h2222;
    cyc();
    check("late_idle_busy", busy, 0);
    check("late_idle_addr", ADDR, 16'h0040);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (ldr_ack) begin
        lat = k;
        break;
      end
    end
    check("late_ldr_lat", lat, 3);
    check("late_ldr_rdata", ldr_rdata, 16'h2222);
    check("late_cpu_rdata_kept", cpu_rdata, 16'h1111);
    check("late_ldr_addr", ADDR, 16'h0050);
    ldr_req = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single SRAM/Mem2IO port between the SLC-3 CPU (MAR/MDR path) and a secondary requester: a program loader or DMA engine. It serializes accesses, holds address and data stable for a fixed number of wait cycles, drives the active-low OE/WE strobes, and returns read data with a one-cycle acknowledge. It sits between the CPU datapath/ISDU and the memory subsystem, replacing the direct MAR-to-ADDR connection.

## Interface
Parameters:
- WAIT_CYCLES, 2, number of cycles OE/WE are held asserted per access; legal range 1–15.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
- cpu_addr  in  16  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  CPU read data; valid from the cycle of cpu_ack, held until the next CPU read completes.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: same as the cpu_* ports, for the loader port.
- ADDR  out  16  SRAM address.
- OE  out  1  output enable, active-low.
- WE  out  1  write enable, active-low.
- Data_to_SRAM  out  16  write data.
- Data_from_SRAM  in  16  read data from SRAM.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: sample requests. If any request is present, latch the winner's addr/wdata/we into ADDR/Data_to_SRAM/op register, record the winner, and go to ACCESS.
  - ACCESS: wait counter loads WAIT_CYCLES−1 on entry and decrements each cycle. OE=0 for a read, or WE=0 for a write, for every ACCESS cycle. When the counter is 0, go to DONE. On the last ACCESS cycle of a read, capture Data_from_SRAM into the winner's rdata register.
  - DONE: OE=WE=1. Winner's ack=1 for this cycle only. Go to IDLE.
- OE and WE are never low together. Both are 1 in IDLE and DONE.
- ADDR and Data_to_SRAM are registered and change only on entry to ACCESS; they hold their last value otherwise.
- Arbitration happens only in IDLE. A request arriving during ACCESS or DONE waits.
- Fixed priority: the CPU wins over the loader when both requests are present in the same IDLE cycle.
- A requester must drop req by the end of the IDLE cycle that follows its ack. A req still high at that edge starts a new transaction.
- rdata of the non-winning port is never modified. A write does not modify rdata.

## Timing
- Reset values: ADDR=0, Data_to_SRAM=0, OE=1, WE=1, cpu_ack=ldr_ack=0, cpu_rdata=ldr_rdata=0, busy=0, state=IDLE, last grant=loader.
- Request sampled at edge E0 in IDLE. ACCESS occupies cycles E0+1 … E0+WAIT_CYCLES. ack is high in cycle E0+WAIT_CYCLES+1. IDLE resumes at E0+WAIT_CYCLES+2.
- Request-to-ack latency is WAIT_CYCLES+1 cycles. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Reset asserted mid-transaction has immediate (asynchronous) effect:
  - OE/WE go to 1.
  - No ack is issued.
  - rdata returns to 0.
  - After release, the state is IDLE. An interrupted write's SRAM contents are undefined.
- A req change during ACCESS or DONE has no effect on the current transaction, whose addr/data/we are latched.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration. On simultaneous requests in IDLE, the port not granted last wins. A single request wins regardless.
  - The last-grant register updates on every grant and resets to loader, so the CPU wins the first tie.
- MEM_ARB_RR_EN undefined: fixed CPU priority, and the last-grant register is not implemented.

## Test plan
- CPU read, WAIT_CYCLES=2, cpu_addr=16'h0010, Data_from_SRAM=16'hBEEF → OE=0 in cycles 1–2 after sampling, cpu_ack high in cycle 3, cpu_rdata=16'hBEEF, ldr_rdata unchanged (0).
- Loader write, ldr_addr=16'h3000, ldr_wdata=16'h1234 → ADDR=16'h3000 and Data_to_SRAM=16'h1234 from cycle 1, WE=0 in cycles 1–2, OE=1 throughout, ldr_ack in cycle 3.
- Both req high continuously, three transactions, fixed priority → the CPU is granted all three and the loader starves. With MEM_ARB_RR_EN → grant order CPU, loader, CPU.
- Reset asserted in the 2nd ACCESS cycle of a CPU read → OE=1 immediately, no cpu_ack, busy=0. A new request after release completes normally in WAIT_CYCLES+1 cycles.
- cpu_req held high through ack with WAIT_CYCLES=1 → acks every 3 cycles. Each read captures the current Data_from_SRAM value (sequence 16'h0001, 16'h0002).
- ldr_req raised during a CPU ACCESS → ignored until IDLE, then granted. ldr_ack arrives WAIT_CYCLES+1 cycles after that IDLE sample.
